prince_keyadd_seq: RTL and testbench

PRINCE_KEYADD_SEQ -- requirements
Module: prince_keyadd_seq

---
 rtl/prince_pkg.sv | 51 +++++
 rtl/prince_share_xor.sv | 15 +
 rtl/prince_keyadd_seq.sv | 142 ++++++++++++++
 tb/tb_prince_keyadd_seq.sv | 226 ++++++++++++++++++++++
 4 files changed

// File: rtl/prince_pkg.sv
// Shared PRINCE constants: default geometry, round-constant table and the k0' whitening-key derivation.
package prince_pkg;

    localparam int unsigned PRINCE_WIDTH  = 64;
    localparam int unsigned PRINCE_SHARES = 2;
    localparam int unsigned PRINCE_ROUNDS = 12;
    localparam int unsigned ROUND_W       = 4;
    // Widest state the k0' helper handles.
    localparam int unsigned KW_MAX        = 128;

    typedef logic [ROUND_W-1:0] round_t;

    // Position of the current beat within a block.
    typedef struct packed {
        logic first;
        logic last;
    } beat_pos_t;

    function automatic logic [63:0] prince_rc(input round_t idx);
        logic [63:0] rc;
        case (idx)
            4'd0:    rc = 64'h0000000000000000;
            4'd1:    rc = 64'h13198a2e03707344;
            4'd2:    rc = 64'ha4093822299f31d0;
            4'd3:    rc = 64'h082efa98ec4e6c89;
            4'd4:    rc = 64'h452821e638d01377;
            4'd5:    rc = 64'hbe5466cf34e90c6c;
            4'd6:    rc = 64'h7ef84f78fd955cb1;
            4'd7:    rc = 64'h85840851f1ac43aa;
            4'd8:    rc = 64'hc882d32f25323c54;
            4'd9:    rc = 64'h64a51195e0e3610d;
            4'd10:   rc = 64'hd3b5a399ca0c2399;
            4'd11:   rc = 64'hc0ac29b7c97c50dd;
            default: rc = 64'h0000000000000000;
        endcase
        return rc;
    endfunction

    // k0' = rotr1(k0) ^ (k0 >> (w-1)) over the low w bits; linear, so safe per share.
    function automatic logic [KW_MAX-1:0] k0_prime(input logic [KW_MAX-1:0] k,
                                                   input int unsigned       w);
        logic [KW_MAX-1:0] mask;
        logic [KW_MAX-1:0] km;
        logic [KW_MAX-1:0] rot;
        mask = (KW_MAX'(1) << w) - KW_MAX'(1);
        km   = k & mask;
        rot  = ((km >> 1) | (km << (w - 1))) & mask;
        return rot ^ (km >> (w - 1));
    endfunction

endpackage

// File: rtl/prince_share_xor.sv
// Share-wise XOR of two masked vectors; each share only ever meets the same share index.
module prince_share_xor #(
    parameter int unsigned WIDTH  = 64,
    parameter int unsigned SHARES = 2
) (
    input  logic [WIDTH*SHARES-1:0] a_i,
    input  logic [WIDTH*SHARES-1:0] b_i,
    output logic [WIDTH*SHARES-1:0] y_c
);

    for (genvar j = 0; j < SHARES; j++) begin : g_share
        assign y_c[j*WIDTH +: WIDTH] = a_i[j*WIDTH +: WIDTH] ^ b_i[j*WIDTH +: WIDTH];
    end

endmodule

// File: rtl/prince_keyadd_seq.sv
// Masked PRINCE key-addition sequencer: one key/round-constant addition per accepted beat, latency 1.
// Optional mask refresh of the key contribution is enabled with PRINCE_KEYADD_REFRESH_EN.
module prince_keyadd_seq
    import prince_pkg::*;
#(
    parameter int unsigned WIDTH  = PRINCE_WIDTH,
    parameter int unsigned SHARES = PRINCE_SHARES,
    parameter int unsigned ROUNDS = PRINCE_ROUNDS
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      clear,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [WIDTH*SHARES-1:0]   x,
    input  logic [WIDTH*SHARES-1:0]   k0,
    input  logic [WIDTH*SHARES-1:0]   k1,
`ifdef PRINCE_KEYADD_REFRESH_EN
    input  logic [WIDTH*(SHARES-1)-1:0] rnd,
`endif
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [WIDTH*SHARES-1:0]   z,
    output logic [ROUND_W-1:0]        round
);

    localparam int unsigned BUS_W = WIDTH * SHARES;

    logic             out_valid_q, out_valid_d;
    logic [BUS_W-1:0] z_q, z_d;
    round_t           round_q, round_d;

    logic             accept_c;
    beat_pos_t        pos;
    logic [BUS_W-1:0] k0_sel;
    logic [BUS_W-1:0] k0p_rc;
    logic [BUS_W-1:0] key_a;
    logic [BUS_W-1:0] key_b;
    logic [BUS_W-1:0] key_m;
    logic [BUS_W-1:0] z_new;

    assign in_ready = !out_valid_q || out_ready;
    assign accept_c = in_valid && in_ready;

    always_comb begin
        pos       = '0;
        pos.first = (round_q == '0);
        pos.last  = (round_q == round_t'(ROUNDS - 1));
    end

    // Select the whitening-key terms per share; the round constant only touches share 0.
    always_comb begin
        k0_sel = '0;
        k0p_rc = '0;
        for (int unsigned j = 0; j < SHARES; j++) begin
            if (pos.first) begin
                k0_sel[j*WIDTH +: WIDTH] = k0[j*WIDTH +: WIDTH];
            end
            if (pos.last) begin
                k0p_rc[j*WIDTH +: WIDTH] =
                    WIDTH'(k0_prime(KW_MAX'(k0[j*WIDTH +: WIDTH]), WIDTH));
            end
        end
        k0p_rc[WIDTH-1:0] = k0p_rc[WIDTH-1:0] ^ WIDTH'(prince_rc(round_q));
    end

    prince_share_xor #(.WIDTH(WIDTH), .SHARES(SHARES)) u_xor_k0 (
        .a_i (k1),
        .b_i (k0_sel),
        .y_c (key_a)
    );

    prince_share_xor #(.WIDTH(WIDTH), .SHARES(SHARES)) u_xor_k0p (
        .a_i (key_a),
        .b_i (k0p_rc),
        .y_c (key_b)
    );

`ifdef PRINCE_KEYADD_REFRESH_EN
    logic [BUS_W-1:0] rnd_mask;
    logic [WIDTH-1:0] rnd_acc;

    // Fresh masks on shares 0..S-2, their XOR on the last share: recombined key unchanged.
    always_comb begin
        rnd_mask = '0;
        rnd_acc  = '0;
        for (int unsigned j = 0; j < SHARES - 1; j++) begin
            rnd_mask[j*WIDTH +: WIDTH] = rnd[j*WIDTH +: WIDTH];
            rnd_acc                    = rnd_acc ^ rnd[j*WIDTH +: WIDTH];
        end
        rnd_mask[(SHARES-1)*WIDTH +: WIDTH] = rnd_acc;
    end

    prince_share_xor #(.WIDTH(WIDTH), .SHARES(SHARES)) u_xor_rnd (
        .a_i (key_b),
        .b_i (rnd_mask),
        .y_c (key_m)
    );
`else
    assign key_m = key_b;
`endif

    prince_share_xor #(.WIDTH(WIDTH), .SHARES(SHARES)) u_xor_x (
        .a_i (x),
        .b_i (key_m),
        .y_c (z_new)
    );

    // Handshake and round sequencing; clear overrides the counter but not the accepted beat.
    always_comb begin
        out_valid_d = out_valid_q;
        z_d         = z_q;
        round_d     = round_q;
        if (accept_c) begin
            out_valid_d = 1'b1;
            z_d         = z_new;
            round_d     = pos.last ? '0 : round_q + round_t'(1);
        end else if (out_ready) begin
            out_valid_d = 1'b0;
        end
        if (clear) begin
            round_d = '0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid_q <= 1'b0;
            z_q         <= '0;
            round_q     <= '0;
        end else begin
            out_valid_q <= out_valid_d;
            z_q         <= z_d;
            round_q     <= round_d;
        end
    end

    assign out_valid = out_valid_q;
    assign z         = z_q;
    assign round     = round_q;

endmodule

// File: tb/tb_prince_keyadd_seq.sv
// Directed scoreboard bench for prince_keyadd_seq at default parameters (64-bit, 2 shares, 12 rounds).
module tb_prince_keyadd_seq;

    logic         clk = 1'b0;
    logic         rst;
    logic         clear;
    logic         in_valid;
    logic         in_ready;
    logic [127:0] x, k0, k1;
    logic         out_valid;
    logic         out_ready;
    logic [127:0] z;
    logic [3:0]   round;
`ifdef PRINCE_KEYADD_REFRESH_EN
    logic [63:0]  rnd = 64'h0;
`endif

    int n_vec = 0;
    int n_err = 0;
    int n_pop = 0;
    int model_round = 0;
    logic [63:0] sb[$];

    logic [63:0] rc_tab [12] = '{
        64'h0000000000000000, 64'h13198a2e03707344, 64'ha4093822299f31d0,
        64'h082efa98ec4e6c89, 64'h452821e638d01377, 64'hbe5466cf34e90c6c,
        64'h7ef84f78fd955cb1, 64'h85840851f1ac43aa, 64'hc882d32f25323c54,
        64'h64a51195e0e3610d, 64'hd3b5a399ca0c2399, 64'hc0ac29b7c97c50dd};

    prince_keyadd_seq dut (
        .clk       (clk),
        .rst       (rst),
        .clear     (clear),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .x         (x),
        .k0        (k0),
        .k1        (k1),
`ifdef PRINCE_KEYADD_REFRESH_EN
        .rnd       (rnd),
`endif
        .out_valid (out_valid),
        .out_ready (out_ready),
        .z         (z),
        .round     (round)
    );

    always #5 clk = ~clk;

`ifdef PRINCE_KEYADD_REFRESH_EN
    always @(negedge clk) rnd = {$urandom, $urandom};
`endif

    function automatic logic [63:0] recomb(input logic [127:0] v);
        return v[63:0] ^ v[127:64];
    endfunction

    // Reference on recombined values (all terms are linear in the shares).
    function automatic logic [63:0] model(input logic [127:0] xi, input logic [127:0] k0i,
                                         input logic [127:0] k1i, input int i);
        logic [63:0] r, kk;
        kk = recomb(k0i);
        r  = recomb(xi) ^ recomb(k1i) ^ rc_tab[i];
        if (i == 0)  r = r ^ kk;
        if (i == 11) r = r ^ {kk[0], kk[63:1]} ^ {63'b0, kk[63]};
        return r;
    endfunction

    function automatic logic [127:0] rnd128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Drive one beat, wait (bounded) for acceptance, push its expected recombined result.
    task automatic send(input logic [127:0] xi, input logic [127:0] k0i, input logic [127:0] k1i,
                        input bit clr, input bit use_exp, input logic [63:0] exp);
        bit ok;
        ok       = 1'b0;
        x        = xi;
        k0       = k0i;
        k1       = k1i;
        clear    = clr;
        in_valid = 1'b1;
        for (int c = 0; c < 64 && !ok; c++) begin
            @(negedge clk);
            if (in_ready === 1'b1) begin
                sb.push_back(use_exp ? exp : model(xi, k0i, k1i, model_round));
                model_round = clr ? 0 : ((model_round == 11) ? 0 : model_round + 1);
                ok = 1'b1;
            end
        end
        n_vec++;
        assert (ok) else begin
            n_err++;
            $error("FAIL accept_timeout: observed in_ready %b expected 1", in_ready);
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        clear    = 1'b0;
    endtask

    task automatic drain();
        for (int c = 0; c < 200 && (sb.size() != 0 || out_valid === 1'b1); c++) @(negedge clk);
        check("drain_empty", 128'(sb.size()), 128'(0));
        @(posedge clk);
        #1;
    endtask

    // Scoreboard side: an output handshake completes at the next posedge.
    always @(negedge clk) begin
        if (rst === 1'b0 && out_valid === 1'b1 && out_ready === 1'b1) begin
            n_vec++;
            assert (sb.size() != 0) else begin
                n_err++;
                $error("FAIL extra_output: observed %h expected no output", z);
            end
            if (sb.size() != 0) begin
                check("z_recomb", 128'(recomb(z)), 128'(sb.pop_front()));
                n_pop++;
            end
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: observed no finish expected finish");
        $fatal(1, "bench timeout");
    end

    initial begin
        int pop0;
        logic [63:0] ea;
        rst = 1'b1; clear = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        x = '0; k0 = '0; k1 = '0;

        // Reset state
        @(negedge clk);
        check("rst_out_valid", 128'(out_valid), 128'(0));
        check("rst_z", z, 128'(0));
        check("rst_round", 128'(round), 128'(0));
        check("rst_in_ready", 128'(in_ready), 128'(1));
        #2 rst = 1'b0;
        @(posedge clk);
        #1;
        out_ready = 1'b1;

        // Known-answer block: beat 0, beat 1, random middle, beat 11
        send('0, 128'h1, '0, 1'b0, 1'b1, 64'h0000000000000001);
        check("beat0_round", 128'(round), 128'(1));
        send('0, '0, '0, 1'b0, 1'b1, 64'h13198a2e03707344);
`ifndef PRINCE_KEYADD_REFRESH_EN
        check("beat1_share1", 128'(z[127:64]), 128'(0));
`endif
        check("beat1_round", 128'(round), 128'(2));
        for (int i = 2; i < 11; i++) send(rnd128(), rnd128(), rnd128(), 1'b0, 1'b0, '0);
        send('0, 128'h1, '0, 1'b0, 1'b1, 64'h40ac29b7c97c50dd);
        check("beat11_wrap", 128'(round), 128'(0));
        drain();

        // Backpressure: hold out_ready low with a beat waiting
        pop0 = n_pop;
        out_ready = 1'b0;
        send(rnd128(), rnd128(), rnd128(), 1'b0, 1'b0, '0);
        ea = sb[0];
        x = rnd128(); k0 = rnd128(); k1 = rnd128(); in_valid = 1'b1;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            check("hold_in_ready", 128'(in_ready), 128'(0));
            check("hold_out_valid", 128'(out_valid), 128'(1));
            check("hold_z", 128'(recomb(z)), 128'(ea));
        end
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        send(x, k0, k1, 1'b0, 1'b0, '0);
        for (int i = 2; i < 12; i++) send(rnd128(), rnd128(), rnd128(), 1'b0, 1'b0, '0);
        drain();
        check("block_count", 128'(n_pop - pop0), 128'(12));
        check("block_round", 128'(round), 128'(0));

        // Clear at round 5 together with an accept
        for (int i = 0; i < 5; i++) send(rnd128(), rnd128(), rnd128(), 1'b0, 1'b0, '0);
        check("pre_clear_round", 128'(round), 128'(5));
        send('0, '0, '0, 1'b1, 1'b1, 64'hbe5466cf34e90c6c);
        check("clear_round", 128'(round), 128'(0));
        send('0, 128'h1, '0, 1'b0, 1'b1, 64'h0000000000000001);
        check("post_clear_round", 128'(round), 128'(1));
        drain();

        // Reset mid-burst with a pending output
        out_ready = 1'b0;
        send(rnd128(), rnd128(), rnd128(), 1'b0, 1'b0, '0);
        @(negedge clk);
        #2 rst = 1'b1;
        #1;
        check("midrst_out_valid", 128'(out_valid), 128'(0));
        check("midrst_round", 128'(round), 128'(0));
        check("midrst_z", z, 128'(0));
        check("midrst_in_ready", 128'(in_ready), 128'(1));
        sb.delete();
        model_round = 0;
        @(negedge clk);
        #2 rst = 1'b0;
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        send('0, 128'h1, '0, 1'b0, 1'b1, 64'h0000000000000001);
        send('0, '0, '0, 1'b0, 1'b1, 64'h13198a2e03707344);
        for (int i = 2; i < 11; i++) send('0, '0, '0, 1'b0, 1'b1, rc_tab[i]);
        send('0, 128'h1, '0, 1'b0, 1'b1, 64'h40ac29b7c97c50dd);
        check("replay_wrap", 128'(round), 128'(0));
        drain();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
